// File: rtl/benes_route_ctrl_if.sv
// Bundle of issue, configuration and crossbar-control signals for the
// Benes route-configuration controller. The master side is the requester /
// configuration agent, the slave side is the controller itself.
interface benes_route_ctrl_if #(
    parameter int SIZE = 32,
    parameter int NCFG = 4
);
    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int HALF     = SIZE / 2;
    localparam int SEL_W    = $clog2(NCFG);
    localparam int STAGE_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic                     in_valid;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_ready;
    logic                     cfg_wr_en;
    logic [SEL_W-1:0]         cfg_slot;
    logic [STAGE_W-1:0]       cfg_stage;
    logic [HALF-1:0]          cfg_word;
    logic                     cfg_clr;
    logic [NCFG-1:0]          slot_valid;
    logic [STAGES*HALF-1:0]   control_bit;
    logic                     out_valid;
    logic [SEL_W-1:0]         out_sel;
    logic                     err;

    modport master (
        output in_valid, in_sel, cfg_wr_en, cfg_slot, cfg_stage, cfg_word, cfg_clr,
        input  in_ready, slot_valid, control_bit, out_valid, out_sel, err
    );

    modport slave (
        input  in_valid, in_sel, cfg_wr_en, cfg_slot, cfg_stage, cfg_word, cfg_clr,
        output in_ready, slot_valid, control_bit, out_valid, out_sel, err
    );
endinterface

// File: rtl/benes_route_ctrl.sv
// Route-configuration controller for a pipelined SIZE-port Benes crossbar.
// Holds NCFG preloaded permutations (STAGES words of HALF switch bits each)
// and, for every accepted transfer, presents each stage's switch word in the
// cycle the transfer's data sits in that stage. Each in-flight transfer
// carries its own snapshot of the remaining stage words, so table rewrites
// after acceptance never disturb it.
module benes_route_ctrl #(
    parameter int SIZE = 32,
    parameter int NCFG = 4
) (
    input logic               clk,
    input logic               rst_n,
    benes_route_ctrl_if.slave bus
);
    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int HALF     = SIZE / 2;
    localparam int SEL_W    = $clog2(NCFG);

    logic [STAGES*HALF-1:0] table_q [NCFG];
    logic [STAGES-1:0]      mask_q  [NCFG];
    logic                   ready_q;
    logic                   err_q;
    logic [NCFG-1:0]        slot_valid;
    logic                   blocked;
    logic                   issue;
    logic                   accept;
    logic                   reject;
    logic                   stage_ok;
    logic [STAGES*HALF-1:0] row;

    assign stage_ok = int'(bus.cfg_stage) < STAGES;

    // Permutation table and loaded masks; a clear on the same slot overrides a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NCFG; n++) begin
                table_q[n] <= '0;
                mask_q[n]  <= '0;
            end
        end else begin
            if (bus.cfg_wr_en && stage_ok) begin
                table_q[bus.cfg_slot][bus.cfg_stage*HALF +: HALF] <= bus.cfg_word;
                mask_q[bus.cfg_slot][bus.cfg_stage]               <= 1'b1;
            end
            if (bus.cfg_clr) begin
                mask_q[bus.cfg_slot] <= '0;
            end
        end
    end

    // A slot is usable only once every stage word has been loaded.
    always_comb begin
        slot_valid = '0;
        for (int n = 0; n < NCFG; n++) begin
            slot_valid[n] = &mask_q[n];
        end
    end

    // Issue is refused while the selected slot is being edited this cycle.
    always_comb begin
        blocked = (bus.cfg_wr_en || bus.cfg_clr) && (bus.cfg_slot == bus.in_sel);
        issue   = bus.in_valid && ready_q && !blocked;
        accept  = issue && slot_valid[bus.in_sel];
        reject  = issue && !slot_valid[bus.in_sel];
        row     = table_q[bus.in_sel];
    end

    // in_ready comes up on the first edge after reset release; err flags a rejected issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            err_q   <= reject;
        end
    end

    assign bus.in_ready   = ready_q && !blocked;
    assign bus.err        = err_q;
    assign bus.slot_valid = slot_valid;

    // Crossbar stage 0 is unregistered, so its bits come straight from the table.
    assign bus.control_bit[HALF-1:0] = accept ? row[HALF-1:0] : '0;

    generate
        if (STAGES == 1) begin : g_comb
            assign bus.out_valid = accept;
            assign bus.out_sel   = bus.in_sel;
        end else begin : g_pipe
            for (genvar s = 1; s < STAGES; s++) begin : g_stage
                logic                       v;
                logic [SEL_W-1:0]           sel;
                logic [(STAGES-s)*HALF-1:0] snap;

                if (s == 1) begin : g_first
                    // Capture the accepted transfer with its stage 1..STAGES-1 words.
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            v    <= 1'b0;
                            sel  <= '0;
                            snap <= '0;
                        end else begin
                            v    <= accept;
                            sel  <= bus.in_sel;
                            snap <= row[STAGES*HALF-1:HALF];
                        end
                    end
                end else begin : g_next
                    // Advance one stage, dropping the word the previous stage consumed.
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            v    <= 1'b0;
                            sel  <= '0;
                            snap <= '0;
                        end else begin
                            v    <= g_stage[s-1].v;
                            sel  <= g_stage[s-1].sel;
                            snap <= g_stage[s-1].snap[(STAGES-s+1)*HALF-1:HALF];
                        end
                    end
                end

                assign bus.control_bit[s*HALF +: HALF] = v ? snap[HALF-1:0] : '0;
            end

            assign bus.out_valid = g_stage[STAGES-1].v;
            assign bus.out_sel   = g_stage[STAGES-1].sel;
        end
    endgenerate
endmodule

// File: tb/tb_benes_route_ctrl.sv
// Testbench for benes_route_ctrl: directed vectors, scoreboard of expected
// crossbar-output transfers popped by an independent monitor.
module tb_benes_route_ctrl;
    localparam int SIZE   = 32;
    localparam int NCFG   = 4;
    localparam int STAGES = 9;
    localparam int HALF   = 16;
    localparam int CW     = STAGES * HALF;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] word;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];

    benes_route_ctrl_if #(.SIZE(SIZE), .NCFG(NCFG)) bus ();

    benes_route_ctrl #(.SIZE(SIZE), .NCFG(NCFG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic iv, input logic [1:0] isel, input logic wr,
                                  input logic [1:0] slot, input logic [3:0] stage,
                                  input logic [15:0] word, input logic clr);
        bus.in_valid  = iv;
        bus.in_sel    = isel;
        bus.cfg_wr_en = wr;
        bus.cfg_slot  = slot;
        bus.cfg_stage = stage;
        bus.cfg_word  = word;
        bus.cfg_clr   = clr;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0);
    endtask

    task automatic load_slot(input logic [1:0] slot, input logic [15:0] word, input logic [8:0] mask);
        for (int st = 0; st < STAGES; st++) begin
            if (mask[st]) begin
                next_cycle();
                apply_stimulus(1'b0, 2'd0, 1'b1, slot, 4'(st), word, 1'b0);
            end
        end
        next_cycle();
        idle();
    endtask

    task automatic issue(input logic [1:0] sel, input bit expect_accept, input logic [15:0] last_word);
        exp_t e;
        apply_stimulus(1'b1, sel, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0);
        if (expect_accept) begin
            e.sel  = sel;
            e.word = last_word;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [CW-1:0] stage_vec(input int s, input logic [15:0] word);
        logic [CW-1:0] v;
        v = '0;
        v[s*HALF +: HALF] = word;
        return v;
    endfunction

    // Monitor: every transfer leaving the crossbar must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_out_valid: got out_sel=%0d expected no transfer", bus.out_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("out_sel", CW'(bus.out_sel), CW'(e.sel));
                check_output("last_stage_bits", CW'(bus.control_bit[(STAGES-1)*HALF +: HALF]), CW'(e.word));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CW-1:0] expv;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_output("rst_control_bit", bus.control_bit, '0);
        check_output("rst_out_valid", CW'(bus.out_valid), '0);
        check_output("rst_slot_valid", CW'(bus.slot_valid), '0);
        check_output("rst_in_ready", CW'(bus.in_ready), '0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("release_in_ready", CW'(bus.in_ready), CW'(1));
        check_output("release_err", CW'(bus.err), '0);

        // Single transfer through slot 1, all stages FFFF
        load_slot(2'd1, 16'hFFFF, 9'h1FF);
        next_cycle();
        issue(2'd1, 1'b1, 16'hFFFF);
        @(negedge clk);
        check_output("t2_stage0", bus.control_bit, stage_vec(0, 16'hFFFF));
        for (int s = 1; s < STAGES; s++) begin
            next_cycle();
            idle();
            @(negedge clk);
            check_output($sformatf("t2_stage%0d", s), bus.control_bit, stage_vec(s, 16'hFFFF));
        end
        check_output("t2_out_valid", CW'(bus.out_valid), CW'(1));

        // Alternating slots 0 (zeros) and 2 (AAAA), back-to-back
        load_slot(2'd0, 16'h0000, 9'h1FF);
        load_slot(2'd2, 16'hAAAA, 9'h1FF);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (i % 2 == 0) issue(2'd0, 1'b1, 16'h0000);
            else            issue(2'd2, 1'b1, 16'hAAAA);
        end
        @(negedge clk);
        expv = '0;
        for (int s = 0; s < STAGES; s++) begin
            if ((9 - s) % 2 == 1) expv[s*HALF +: HALF] = 16'hAAAA;
        end
        check_output("t3_pipeline_mix", bus.control_bit, expv);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            idle();
        end

        // Slot 3 with stage 8 missing is rejected
        load_slot(2'd3, 16'h1234, 9'h0FF);
        next_cycle();
        issue(2'd3, 1'b0, 16'h0);
        @(negedge clk);
        check_output("t4_slot_valid", CW'(bus.slot_valid), CW'(4'b0111));
        check_output("t4_in_ready", CW'(bus.in_ready), CW'(1));
        check_output("t4_stage0_zero", bus.control_bit, '0);
        next_cycle();
        idle();
        @(negedge clk);
        check_output("t4_err_pulse", CW'(bus.err), CW'(1));
        check_output("t4_stage1_zero", bus.control_bit, '0);
        next_cycle();
        @(negedge clk);
        check_output("t4_err_clear", CW'(bus.err), '0);
        for (int i = 0; i < 9; i++) next_cycle();

        // Table rewrite after accept does not alter an in-flight transfer
        next_cycle();
        issue(2'd1, 1'b1, 16'hFFFF);
        next_cycle();
        idle();
        next_cycle();
        apply_stimulus(1'b0, 2'd1, 1'b1, 2'd1, 4'd5, 16'h0000, 1'b0);
        @(negedge clk);
        check_output("t5_wr_blocks_ready", CW'(bus.in_ready), '0);
        check_output("t5_stage2", bus.control_bit, stage_vec(2, 16'hFFFF));
        for (int s = 3; s <= 5; s++) begin
            next_cycle();
            idle();
        end
        @(negedge clk);
        check_output("t5_inflight_stage5", bus.control_bit, stage_vec(5, 16'hFFFF));
        for (int i = 0; i < 6; i++) next_cycle();
        issue(2'd1, 1'b1, 16'hFFFF);
        for (int s = 1; s <= 5; s++) begin
            next_cycle();
            idle();
        end
        @(negedge clk);
        check_output("t5_new_stage5_zero", bus.control_bit, '0);
        for (int i = 0; i < 6; i++) next_cycle();
        apply_stimulus(1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 16'h0, 1'b1);
        @(negedge clk);
        check_output("t5_clr_other_slot_ready", CW'(bus.in_ready), CW'(1));
        next_cycle();
        apply_stimulus(1'b0, 2'd1, 1'b1, 2'd1, 4'd0, 16'h5555, 1'b1);
        @(negedge clk);
        check_output("t5_clr_blocks_ready", CW'(bus.in_ready), '0);
        next_cycle();
        idle();
        @(negedge clk);
        check_output("t5_clr_wins", CW'(bus.slot_valid), CW'(4'b0101));

        // Reset with four transfers in flight
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            issue(2'd2, 1'b1, 16'hAAAA);
        end
        next_cycle();
        idle();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("t6_rst_control_bit", bus.control_bit, '0);
        check_output("t6_rst_out_valid", CW'(bus.out_valid), '0);
        check_output("t6_rst_in_ready", CW'(bus.in_ready), '0);
        check_output("t6_rst_slot_valid", CW'(bus.slot_valid), '0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("t6_release_in_ready", CW'(bus.in_ready), CW'(1));
        check_output("t6_release_control_bit", bus.control_bit, '0);
        for (int i = 0; i < 12; i++) next_cycle();
        @(negedge clk);
        check_output("t6_quiet_control_bit", bus.control_bit, '0);

        // Drain: every expected transfer must have appeared
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
        check_output("scoreboard_empty", CW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
